// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Sole writer of the integer register file. After reset it zero-fills
//   x1..x(2**ADDR_W-1) through the write port. It then arbitrates ALU and LSU
//   write-back requests onto that port. The LSU normally wins a conflict. An
//   ALU that has lost STARVE_MAX arbitrations in a row takes priority.
//
// Handshake: a requester raises valid with rd/data stable. The request is
//   accepted in any cycle where valid && ready. ready is combinational from
//   valid and the starvation state. An accepted request appears on the write
//   port one cycle later. A requester keeps valid, rd and data unchanged until
//   it is accepted.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alu_valid/rd/data/ready  ALU write-back request channel
//   lsu_valid/rd/data/ready  LSU load-return write-back request channel
//   rdWrite/rdAddr/rdData    registered register-file write port
//   init_done                registered, high once the zero-fill has completed
//   dbg_state                current FSM state (0 = CLEAR, 1 = RUN)
//   dbg_scnt                 current starvation count
module regfile_wb_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int STARVE_MAX     = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              rdWrite,
    output logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData,
    output logic              init_done,
    output logic              dbg_state,
    output logic [3:0]        dbg_scnt
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG    = '1;
    localparam logic [ADDR_W-1:0] FIRST_REG   = ADDR_W'(1);
    localparam logic [3:0]        STARVE_LIM  = 4'(STARVE_MAX);
    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic              RESET_INIT  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [3:0]        r_scnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_init;
    logic              w_pri_alu;
    logic              w_alu_ready;
    logic              w_lsu_ready;

    // Next state and grant. Both readies stay low while clearing, so no
    // request can be lost behind the zero-fill.
    always_comb begin
        w_next_state = r_state;
        w_alu_ready  = 1'b0;
        w_lsu_ready  = 1'b0;
        w_pri_alu    = (r_scnt >= STARVE_LIM);
        case (r_state)
            ST_CLEAR: begin
                if (r_ptr == LAST_REG) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_lsu_ready = lsu_valid && !(w_pri_alu && alu_valid);
                w_alu_ready = alu_valid && (!lsu_valid || w_pri_alu);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_init <= RESET_INIT;
            r_ptr  <= FIRST_REG;
            r_scnt <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_wr   <= 1'b1;
                r_addr <= r_ptr;
                r_data <= '0;
                r_ptr  <= r_ptr + FIRST_REG;
                if (r_ptr == LAST_REG) begin
                    r_init <= 1'b1;
                end
            end else if (w_alu_ready) begin
                // x0 is hardwired to zero: the request is accepted but no write
                // is issued, and the port keeps its previous address/data.
                r_wr <= (alu_rd != '0);
                if (alu_rd != '0) begin
                    r_addr <= alu_rd;
                    r_data <= alu_data;
                end
            end else if (w_lsu_ready) begin
                r_wr <= (lsu_rd != '0);
                if (lsu_rd != '0) begin
                    r_addr <= lsu_rd;
                    r_data <= lsu_data;
                end
            end else begin
                r_wr <= 1'b0;
            end

            // Counts consecutive cycles in which the ALU waited, saturating at 15.
            if (alu_valid && !w_alu_ready) begin
                if (r_scnt != 4'hF) begin
                    r_scnt <= r_scnt + 4'd1;
                end
            end else begin
                r_scnt <= '0;
            end
        end
    end

    assign alu_ready = w_alu_ready;
    assign lsu_ready = w_lsu_ready;
    assign rdWrite   = r_wr;
    assign rdAddr    = r_addr;
    assign rdData    = r_data;
    assign init_done = r_init;
    assign dbg_state = r_state;
    assign dbg_scnt  = r_scnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter. u_dut runs with the zero-fill
//   enabled. u_dut_nc runs with CLEAR_ON_RESET=0 and has its own stimulus.
//   Inputs change on the falling edge. Registered outputs are sampled on the
//   falling edge, and readies are sampled 1 ns after the inputs change.
module tb_regfile_wb_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        rdWrite, init_done;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic        dbg_state;
    logic [3:0]  dbg_scnt;

    logic        rst_nc;
    logic        alu_valid_nc, lsu_valid_nc;
    logic [4:0]  alu_rd_nc, lsu_rd_nc;
    logic [31:0] alu_data_nc, lsu_data_nc;
    logic        alu_ready_nc, lsu_ready_nc;
    logic        rdWrite_nc, init_done_nc;
    logic [4:0]  rdAddr_nc;
    logic [31:0] rdData_nc;
    logic        dbg_state_nc;
    logic [3:0]  dbg_scnt_nc;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rdWrite(rdWrite), .rdAddr(rdAddr), .rdData(rdData), .init_done(init_done),
        .dbg_state(dbg_state), .dbg_scnt(dbg_scnt)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3), .CLEAR_ON_RESET(0)) u_dut_nc (
        .clk(clk), .rst(rst_nc),
        .alu_valid(alu_valid_nc), .alu_rd(alu_rd_nc), .alu_data(alu_data_nc), .alu_ready(alu_ready_nc),
        .lsu_valid(lsu_valid_nc), .lsu_rd(lsu_rd_nc), .lsu_data(lsu_data_nc), .lsu_ready(lsu_ready_nc),
        .rdWrite(rdWrite_nc), .rdAddr(rdAddr_nc), .rdData(rdData_nc), .init_done(init_done_nc),
        .dbg_state(dbg_state_nc), .dbg_scnt(dbg_scnt_nc)
    );

    // A requester never withdraws an unaccepted request.
    a_alu_hold: assert property (@(posedge clk) disable iff (!rst)
        (alu_valid && !alu_ready) |=> alu_valid)
        else $error("alu_valid dropped before acceptance");
    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst)
        (lsu_valid && !lsu_ready) |=> lsu_valid)
        else $error("lsu_valid dropped before acceptance");

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Checks n clear-sequence edges on u_dut. On the 31st edge the FSM is in
    // RUN, so lsu_ready then follows lsu_valid (no ALU request is pending).
    task automatic clear_seq(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("clr_wr%0d", k),   rdWrite, 1);
            chk($sformatf("clr_addr%0d", k), rdAddr, k);
            chk($sformatf("clr_data%0d", k), rdData, 0);
            chk($sformatf("clr_alurdy%0d", k), alu_ready, 0);
            chk($sformatf("clr_lsurdy%0d", k), lsu_ready, (k == 31) ? lsu_valid : 1'b0);
            chk($sformatf("clr_init%0d", k), init_done, (k == 31) ? 1 : 0);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] lsu_rds[4];
    logic       exp_alu_grant[5];
    int         li;
    int         gcount;
    logic       a_acc, l_acc;
    logic [36:0] e;

    initial begin
        rst = 1'b0;
        rst_nc = 1'b0;
        idle_inputs();
        alu_valid_nc = 1'b1; alu_rd_nc = 5'd3; alu_data_nc = 32'h0000_0033;
        lsu_valid_nc = 1'b0; lsu_rd_nc = '0; lsu_data_nc = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr",    rdWrite, 0);
        chk("rst_addr",  rdAddr, 0);
        chk("rst_data",  rdData, 0);
        chk("rst_init",  init_done, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_scnt",  dbg_scnt, 0);
        chk("nc_rst_init", init_done_nc, 1);
        chk("nc_rst_wr",   rdWrite_nc, 0);

        // CLEAR_ON_RESET=0: the ALU is accepted in the very first cycle.
        @(negedge clk);
        rst_nc = 1'b1;
        #1;
        chk("nc_alurdy", alu_ready_nc, 1);
        chk("nc_lsurdy", lsu_ready_nc, 0);
        @(negedge clk);
        chk("nc_wr",   rdWrite_nc, 1);
        chk("nc_addr", rdAddr_nc, 3);
        chk("nc_data", rdData_nc, 32'h0000_0033);
        alu_valid_nc = 1'b0;
        @(negedge clk);
        chk("nc_wr_off", rdWrite_nc, 0);

        // Clear sequence. An LSU x0 request waits through it and is accepted
        // in the first RUN cycle.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        rst = 1'b1;
        clear_seq(31);
        @(negedge clk);
        chk("clr_end_wr", rdWrite, 0);
        chk("run_state", dbg_state, 1);
        lsu_valid = 1'b0;

        // Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("alu1_rdy", alu_ready, 1);
        chk("alu1_lrdy", lsu_ready, 0);
        @(negedge clk);
        chk("alu1_wr",   rdWrite, 1);
        chk("alu1_addr", rdAddr, 5);
        chk("alu1_data", rdData, 32'hDEAD_BEEF);
        alu_valid = 1'b0;

        // x0 drop after a real write: accepted, no write, port holds.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        chk("x0_rdy", lsu_ready, 1);
        @(negedge clk);
        chk("x0_wr",   rdWrite, 0);
        chk("x0_addr", rdAddr, 5);
        chk("x0_data", rdData, 32'hDEAD_BEEF);
        lsu_valid = 1'b0;

        // Conflict with starvation: expected order LSU 8,9,10, ALU 7, LSU 11.
        lsu_rds = '{5'd8, 5'd9, 5'd10, 5'd11};
        exp_alu_grant = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.push_back({5'd8,  32'h0000_0080});
        exp_q.push_back({5'd9,  32'h0000_0090});
        exp_q.push_back({5'd10, 32'h0000_00A0});
        exp_q.push_back({5'd7,  32'h0000_0011});
        exp_q.push_back({5'd11, 32'h0000_00B0});
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0011;
        li = 0;
        lsu_valid = 1'b1; lsu_rd = lsu_rds[0]; lsu_data = {27'd0, lsu_rds[0]} << 4;
        gcount = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            chk($sformatf("one_hot%0d", cyc), {31'd0, alu_ready && lsu_ready}, 0);
            if (alu_ready || lsu_ready) begin
                if (gcount < 5) chk($sformatf("grant_alu%0d", gcount), alu_ready, exp_alu_grant[gcount]);
                if (gcount == 3) chk("scnt_at_pri", dbg_scnt, 3);
                gcount++;
            end
            a_acc = alu_ready;
            l_acc = lsu_ready;
            @(negedge clk);
            if (rdWrite) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("extra_wr%0d", cyc), rdWrite, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("cf_addr%0d", cyc), rdAddr, e[36:32]);
                    chk($sformatf("cf_data%0d", cyc), rdData, e[31:0]);
                end
            end
            if (a_acc) alu_valid = 1'b0;
            if (l_acc) begin
                li++;
                if (li < 4) begin
                    lsu_rd = lsu_rds[li];
                    lsu_data = {27'd0, lsu_rds[li]} << 4;
                end else begin
                    lsu_valid = 1'b0;
                end
            end
        end
        chk("cf_pending", exp_q.size(), 0);
        chk("cf_grants", gcount, 5);
        chk("cf_scnt", dbg_scnt, 0);
        idle_inputs();

        // Reset mid-clear: fresh reset, run to rdAddr=12, reset again.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_seq(12);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_wr",   rdWrite, 0);
        chk("mid_addr", rdAddr, 0);
        chk("mid_init", init_done, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_seq(31);
        @(negedge clk);
        chk("mid_end_wr", rdWrite, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
